// File: rtl/aes_key_sched.sv
// aes_key_sched: on-the-fly AES-128 key expansion, one round key per next_i step.
// Holds only the current round key and round constant; rounds 0..NR are produced in order.
// Optional feature macro: AES_KEY_SCHED_REWIND_EN adds rewind_i and a stored cipher key
// so the schedule can restart at round 0 without reloading.
module aes_key_sched #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         load_i,
    input  logic [127:0] key_i,
    input  logic         next_i,
`ifdef AES_KEY_SCHED_REWIND_EN
    input  logic         rewind_i,
`endif
    output logic [127:0] rnd_key_o,
    output logic [3:0]   rnd_idx_o,
    output logic         valid_o,
    output logic         last_o,
    output logic         busy_o
);

    // Only the AES-128 round count is supported.
    if (NR != 10) begin : g_nr_check
        $error("aes_key_sched: NR must be 10");
    end

    localparam logic [3:0] LastIdx = 4'(NR);

    // Forward S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    // Entry x sits at bit offset (255 - x) * 8, i.e. {~x, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SboxTable[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         valid_q, valid_d;
    logic [127:0] step_key;

`ifdef AES_KEY_SCHED_REWIND_EN
    logic [127:0] stored_q, stored_d;
    logic         loaded_q, loaded_d;
`endif

    assign step_key = key_step(key_q, rcon_q);

    // Next-state: load_i beats rewind_i beats next_i.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        valid_d = valid_q;
`ifdef AES_KEY_SCHED_REWIND_EN
        stored_d = stored_q;
        loaded_d = loaded_q;
`endif
        if (load_i) begin
            state_d = StActive;
            key_d   = key_i;
            idx_d   = 4'd0;
            rcon_d  = 8'h01;
            valid_d = 1'b1;
`ifdef AES_KEY_SCHED_REWIND_EN
            stored_d = key_i;
            loaded_d = 1'b1;
`endif
        end
`ifdef AES_KEY_SCHED_REWIND_EN
        else if (rewind_i && loaded_q) begin
            state_d = StActive;
            key_d   = stored_q;
            idx_d   = 4'd0;
            rcon_d  = 8'h01;
            valid_d = 1'b1;
        end
`endif
        else if (state_q == StActive && next_i) begin
            if (idx_q != LastIdx) begin
                key_d  = step_key;
                idx_d  = idx_q + 4'd1;
                rcon_d = xtime(rcon_q);
            end else begin
                // Retire; the final round key stays visible on rnd_key_o.
                state_d = StIdle;
                valid_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
            key_q   <= '0;
            idx_q   <= 4'd0;
            rcon_q  <= 8'h01;
            valid_q <= 1'b0;
`ifdef AES_KEY_SCHED_REWIND_EN
            stored_q <= '0;
            loaded_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            valid_q <= valid_d;
`ifdef AES_KEY_SCHED_REWIND_EN
            stored_q <= stored_d;
            loaded_q <= loaded_d;
`endif
        end
    end

    assign rnd_key_o = key_q;
    assign rnd_idx_o = idx_q;
    assign valid_o   = valid_q;
    assign busy_o    = (state_q == StActive);
    assign last_o    = valid_q && (idx_q == LastIdx);

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched using FIPS-197 key expansion vectors.
module tb_aes_key_sched;

    localparam logic [127:0] KeyA   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RkA1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RkA2   = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] RkA4   = 128'hef44a541a8525b7fb671253bdb0bad00;
    localparam logic [127:0] RkA10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KeyB   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RkB1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         load_i = 1'b0;
    logic [127:0] key_i = '0;
    logic         next_i = 1'b0;
`ifdef AES_KEY_SCHED_REWIND_EN
    logic         rewind_i = 1'b0;
`endif
    logic [127:0] rnd_key_o;
    logic [3:0]   rnd_idx_o;
    logic         valid_o;
    logic         last_o;
    logic         busy_o;

    int checks = 0;
    int errors = 0;

    aes_key_sched #(.NR(10)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .load_i   (load_i),
        .key_i    (key_i),
        .next_i   (next_i),
`ifdef AES_KEY_SCHED_REWIND_EN
        .rewind_i (rewind_i),
`endif
        .rnd_key_o(rnd_key_o),
        .rnd_idx_o(rnd_idx_o),
        .valid_o  (valid_o),
        .last_o   (last_o),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state while nrst is held low.
        #2;
        chk("rst_key", rnd_key_o, '0);
        chk("rst_idx", 128'(rnd_idx_o), 128'd0);
        chk("rst_valid", 128'(valid_o), 128'd0);
        chk("rst_last", 128'(last_o), 128'd0);
        chk("rst_busy", 128'(busy_o), 128'd0);
        #11 nrst = 1'b1;

        // next_i in IDLE is ignored.
        next_i = 1'b1;
        cyc();
        next_i = 1'b0;
        chk("idle_next_valid", 128'(valid_o), 128'd0);
        chk("idle_next_idx", 128'(rnd_idx_o), 128'd0);

        // Load key A: one-cycle latency.
        key_i  = KeyA;
        load_i = 1'b1;
        cyc();
        load_i = 1'b0;
        chk("load_valid", 128'(valid_o), 128'd1);
        chk("load_idx", 128'(rnd_idx_o), 128'd0);
        chk("load_key", rnd_key_o, KeyA);
        chk("load_busy", 128'(busy_o), 128'd1);
        chk("load_last", 128'(last_o), 128'd0);

        // Single step.
        next_i = 1'b1;
        cyc();
        next_i = 1'b0;
        chk("r1_idx", 128'(rnd_idx_o), 128'd1);
        chk("r1_key", rnd_key_o, RkA1);

        // Hold with next_i low.
        repeat (3) cyc();
        chk("hold_key", rnd_key_o, RkA1);
        chk("hold_idx", 128'(rnd_idx_o), 128'd1);

        // Run through to round 10.
        next_i = 1'b1;
        cyc();
        chk("r2_key", rnd_key_o, RkA2);
        repeat (2) cyc();
        chk("r4_key", rnd_key_o, RkA4);
        repeat (6) cyc();
        chk("r10_idx", 128'(rnd_idx_o), 128'd10);
        chk("r10_key", rnd_key_o, RkA10);
        chk("r10_last", 128'(last_o), 128'd1);
        chk("r10_valid", 128'(valid_o), 128'd1);

        // One more step retires the schedule.
        cyc();
        next_i = 1'b0;
        chk("ret_valid", 128'(valid_o), 128'd0);
        chk("ret_busy", 128'(busy_o), 128'd0);
        chk("ret_last", 128'(last_o), 128'd0);
        chk("ret_key", rnd_key_o, RkA10);

        next_i = 1'b1;
        repeat (2) cyc();
        next_i = 1'b0;
        chk("ret_next_valid", 128'(valid_o), 128'd0);
        chk("ret_next_key", rnd_key_o, RkA10);

`ifdef AES_KEY_SCHED_REWIND_EN
        // Rewind from IDLE restores round 0 of the stored key.
        rewind_i = 1'b1;
        cyc();
        rewind_i = 1'b0;
        chk("rew_idx", 128'(rnd_idx_o), 128'd0);
        chk("rew_key", rnd_key_o, KeyA);
        chk("rew_valid", 128'(valid_o), 128'd1);
        next_i = 1'b1;
        cyc();
        next_i = 1'b0;
        chk("rew_r1_key", rnd_key_o, RkA1);
`endif

        // Reload mid-schedule with simultaneous next_i: load wins.
        key_i  = KeyA;
        load_i = 1'b1;
        cyc();
        load_i = 1'b0;
        next_i = 1'b1;
        repeat (4) cyc();
        chk("mid_idx", 128'(rnd_idx_o), 128'd4);
        chk("mid_key", rnd_key_o, RkA4);
        key_i  = KeyB;
        load_i = 1'b1;
        cyc();
        load_i = 1'b0;
        chk("ld_next_idx", 128'(rnd_idx_o), 128'd0);
        chk("ld_next_key", rnd_key_o, KeyB);
        cyc();
        next_i = 1'b0;
        chk("b1_idx", 128'(rnd_idx_o), 128'd1);
        chk("b1_key", rnd_key_o, RkB1);

        // Asynchronous reset between edges at round 6.
        next_i = 1'b1;
        repeat (5) cyc();
        next_i = 1'b0;
        chk("pre_rst_idx", 128'(rnd_idx_o), 128'd6);
        #3 nrst = 1'b0;
        #1;
        chk("arst_key", rnd_key_o, '0);
        chk("arst_idx", 128'(rnd_idx_o), 128'd0);
        chk("arst_valid", 128'(valid_o), 128'd0);
        chk("arst_busy", 128'(busy_o), 128'd0);
        chk("arst_last", 128'(last_o), 128'd0);
        #2 nrst = 1'b1;

        // After reset, next_i (and rewind_i, if present) must do nothing.
        next_i = 1'b1;
`ifdef AES_KEY_SCHED_REWIND_EN
        rewind_i = 1'b1;
`endif
        repeat (2) cyc();
        next_i = 1'b0;
`ifdef AES_KEY_SCHED_REWIND_EN
        rewind_i = 1'b0;
`endif
        chk("post_rst_valid", 128'(valid_o), 128'd0);
        chk("post_rst_idx", 128'(rnd_idx_o), 128'd0);
        chk("post_rst_key", rnd_key_o, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
